// File: rtl/wasm_mem_pkg.sv
// +----------------------------------------------------------------------------+
// | wasm_mem_pkg : shared types and helpers for the genram store engine        |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package wasm_mem_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   localparam int C_DEF_AW    = 5;
   localparam int C_DEF_DW    = 8;
   localparam int C_DEF_EXTRA = 4;

   // Packed store bus width: EXTRA**2 words of DW bits.
   function automatic int data_width(input int extra, input int dw);
      return extra * extra * dw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/genram_core.sv
// +----------------------------------------------------------------------------+
// | genram_core : single write port, registered read port storage, no reset    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module genram_core #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] r_mem [2**AW];

   // Read samples the pre-write contents, giving read-before-write on collision.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      rdata <= r_mem[raddr];
   end

endmodule

`default_nettype wire

// File: rtl/genram.sv
// +----------------------------------------------------------------------------+
// | genram   : multi-word store engine with range check over a small RAM       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module genram
   import wasm_mem_pkg::*;
#(
   parameter int AW    = C_DEF_AW,
   parameter int DW    = C_DEF_DW,
   parameter int EXTRA = C_DEF_EXTRA
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [AW-1:0]                      wr_addr,
   input  logic [EXTRA-1:0]                   wr_extra,
   input  logic [data_width(EXTRA, DW)-1:0]   wr_data,
   output logic                               busy,
   output logic                               done,
   output logic                               error,
   input  logic [AW-1:0]                      rd_addr,
   output logic [DW-1:0]                      rd_data
);

   localparam int C_DATA_W = data_width(EXTRA, DW);
   localparam int C_NPOS   = 2**AW;

   state_t               r_state;
   logic [AW-1:0]        r_addr;
   logic [EXTRA-1:0]     r_extra;
   logic [EXTRA-1:0]     r_idx;
   logic [C_DATA_W-1:0]  r_data;
   logic                 r_done;
   logic                 r_error;
   logic                 r_rd_en;

   logic                 w_accept;
   logic [AW:0]          w_end;
   logic                 w_range_err;
   logic                 w_last;
   logic                 w_we;
   logic [AW-1:0]        w_waddr;
   logic [EXTRA-1:0]     w_sel;
   int                   w_base;
   logic [DW-1:0]        w_wdata;
   logic [DW-1:0]        w_core_q;

   assign w_accept    = wr_valid && (r_state == ST_IDLE);
   assign w_end       = {1'b0, wr_addr} + (AW+1)'(wr_extra);
   assign w_range_err = (w_end >= (AW+1)'(C_NPOS));
   assign w_last      = (r_idx == r_extra);
   assign w_we        = (r_state == ST_WRITE);
   assign w_waddr     = r_addr + AW'(r_idx);

   // Word 0 sits highest within the low (extra+1) words of the bus.
   assign w_sel       = r_extra - r_idx;
   assign w_base      = int'(w_sel) * DW;
   assign w_wdata     = r_data[w_base +: DW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_extra <= '0;
         r_idx   <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_range_err) begin
                     r_error <= 1'b1;
                  end else begin
                     r_state <= ST_WRITE;
                     r_idx   <= '0;
                     r_addr  <= wr_addr;
                     r_extra <= wr_extra;
                     r_data  <= wr_data;
                  end
               end
            end
            ST_WRITE: begin
               if (w_last) begin
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + EXTRA'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Storage has no reset, so read data is held at zero until the first post-reset read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en <= 1'b0;
      end else begin
         r_rd_en <= 1'b1;
      end
   end

   genram_core #(
      .AW (AW),
      .DW (DW)
   ) u_core (
      .clk   (clk),
      .we    (w_we),
      .waddr (w_waddr),
      .wdata (w_wdata),
      .raddr (rd_addr),
      .rdata (w_core_q)
   );

   assign wr_ready = (r_state == ST_IDLE);
   assign busy     = (r_state == ST_WRITE);
   assign done     = r_done;
   assign error    = r_error;
   assign rd_data  = {DW{r_rd_en}} & w_core_q;

endmodule

`default_nettype wire

// File: tb/tb_genram.sv
// +----------------------------------------------------------------------------+
// | tb_genram : randomized self-checking bench for genram                      |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_genram;

   localparam int AW     = 5;
   localparam int DW     = 8;
   localparam int EXTRA  = 4;
   localparam int NPOS   = 32;
   localparam int DATA_W = 128;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              wr_valid = 1'b0;
   logic              wr_ready;
   logic [AW-1:0]     wr_addr  = '0;
   logic [EXTRA-1:0]  wr_extra = '0;
   logic [DATA_W-1:0] wr_data  = '0;
   logic              busy;
   logic              done;
   logic              error;
   logic [AW-1:0]     rd_addr  = '0;
   logic [DW-1:0]     rd_data;

   logic [DW-1:0]     ref_mem [NPOS];
   int                tests = 0;
   int                fails = 0;

   genram #(.AW(AW), .DW(DW), .EXTRA(EXTRA)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_extra (wr_extra),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_W-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Byte i of an (n+1)-word store, counting from the most significant used word.
   function automatic logic [DW-1:0] word_of(input logic [DATA_W-1:0] d, input int n, input int i);
      logic [DATA_W-1:0] s;
      s = d >> ((n - i) * DW);
      return s[DW-1:0];
   endfunction

   function automatic bit store_fits(input int addr, input int ext);
      return (addr + ext) < NPOS;
   endfunction

   function automatic void model_store(input int addr, input int ext, input logic [DATA_W-1:0] d);
      if (store_fits(addr, ext)) begin
         for (int i = 0; i <= ext; i++) ref_mem[addr + i] = word_of(d, ext, i);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_word(input int addr, output logic [DW-1:0] q);
      rd_addr = AW'(addr);
      tick();
      q = rd_data;
   endtask

   // Issues one store and observes outputs for ext+4 cycles after the accept edge.
   task automatic do_store(input int addr, input int ext, input logic [DATA_W-1:0] d,
                           output int first_done, output int n_done, output int first_err,
                           output int n_err, output int n_busy, output int n_both);
      int k;
      first_done = -1; n_done = 0; first_err = -1; n_err = 0; n_busy = 0; n_both = 0;
      k = 0;
      while (!wr_ready && k < 50) begin tick(); k++; end
      tests++;
      if (wr_ready !== 1'b1) begin
         fails++;
         $display("FAIL store_ready_timeout: wr_ready=%b required 1", wr_ready);
      end
      wr_valid = 1'b1; wr_addr = AW'(addr); wr_extra = EXTRA'(ext); wr_data = d;
      tick();
      wr_valid = 1'b0; wr_addr = AW'($urandom); wr_extra = EXTRA'($urandom); wr_data = rand_data();
      for (int c = 0; c <= ext + 3; c++) begin
         if (done === 1'b1) begin n_done++; if (first_done < 0) first_done = c; end
         if (error === 1'b1) begin n_err++; if (first_err < 0) first_err = c; end
         if (busy === 1'b1) n_busy++;
         if (done === 1'b1 && error === 1'b1) n_both++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      tests++;
      if ({busy, done, error} !== 3'b000 || rd_data !== 8'h00) begin
         fails++;
         $display("FAIL reset_outputs: busy=%b done=%b error=%b rd_data=%h required 0 0 0 00",
                  busy, done, error, rd_data);
      end
      rst_n = 1'b1;
      tick();
      tests++;
      if (wr_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: wr_ready=%b busy=%b required 1 0", wr_ready, busy);
      end
   endtask

   task automatic test_fill();
      int fd, nd, fe, ne, nb, nboth;
      logic [DATA_W-1:0] d;
      logic [DW-1:0] got;
      for (int base = 0; base < NPOS; base += 16) begin
         d = rand_data();
         do_store(base, 15, d, fd, nd, fe, ne, nb, nboth);
         model_store(base, 15, d);
         tests++;
         if (fd !== 16 || nd !== 1 || ne !== 0 || nb !== 16 || nboth !== 0) begin
            fails++;
            $display("FAIL fill_store: done_at=%0d n_done=%0d n_err=%0d busy=%0d required 16 1 0 16",
                     fd, nd, ne, nb);
         end
      end
      for (int a = 0; a < NPOS; a++) begin
         read_word(a, got);
         tests++;
         if (got !== ref_mem[a]) begin
            fails++;
            $display("FAIL fill_mem[%0d]: got %h required %h", a, got, ref_mem[a]);
         end
      end
   endtask

   task automatic test_single();
      int fd, nd, fe, ne, nb, nboth;
      logic [DATA_W-1:0] d;
      logic [DW-1:0] got;
      d = rand_data();
      d[7:0] = 8'hA5;
      do_store(3, 0, d, fd, nd, fe, ne, nb, nboth);
      model_store(3, 0, d);
      tests++;
      if (fd !== 1 || nd !== 1 || ne !== 0 || nb !== 1) begin
         fails++;
         $display("FAIL single_latency: done_at=%0d n_done=%0d n_err=%0d busy=%0d required 1 1 0 1",
                  fd, nd, ne, nb);
      end
      read_word(3, got);
      tests++;
      if (got !== 8'hA5) begin
         fails++;
         $display("FAIL single_read: got %h required a5", got);
      end
   endtask

   task automatic test_multi();
      int fd, nd, fe, ne, nb, nboth;
      logic [DATA_W-1:0] d;
      logic [DW-1:0] got;
      logic [DW-1:0] exp_b [4];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      d = rand_data();
      d[31:0] = 32'h11223344;
      do_store(4, 3, d, fd, nd, fe, ne, nb, nboth);
      model_store(4, 3, d);
      tests++;
      if (fd !== 4 || nd !== 1 || ne !== 0 || nb !== 4) begin
         fails++;
         $display("FAIL multi_latency: done_at=%0d n_done=%0d n_err=%0d busy=%0d required 4 1 0 4",
                  fd, nd, ne, nb);
      end
      for (int i = 0; i < 4; i++) begin
         read_word(4 + i, got);
         tests++;
         if (got !== exp_b[i]) begin
            fails++;
            $display("FAIL multi_read[%0d]: got %h required %h", 4 + i, got, exp_b[i]);
         end
      end
   endtask

   task automatic test_boundary();
      int fd, nd, fe, ne, nb, nboth;
      logic [DATA_W-1:0] d;
      logic [DW-1:0] got;
      d = rand_data();
      do_store(28, 3, d, fd, nd, fe, ne, nb, nboth);
      model_store(28, 3, d);
      tests++;
      if (fd !== 4 || nd !== 1 || ne !== 0) begin
         fails++;
         $display("FAIL boundary_ok: done_at=%0d n_done=%0d n_err=%0d required 4 1 0", fd, nd, ne);
      end
      d = rand_data();
      do_store(29, 3, d, fd, nd, fe, ne, nb, nboth);
      tests++;
      if (fe !== 0 || ne !== 1 || nd !== 0 || nb !== 0 || nboth !== 0) begin
         fails++;
         $display("FAIL boundary_err: err_at=%0d n_err=%0d n_done=%0d busy=%0d required 0 1 0 0",
                  fe, ne, nd, nb);
      end
      for (int a = 0; a < NPOS; a++) begin
         read_word(a, got);
         tests++;
         if (got !== ref_mem[a]) begin
            fails++;
            $display("FAIL boundary_mem[%0d]: got %h required %h", a, got, ref_mem[a]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] da, db;
      logic [DW-1:0] got;
      int bad, cnt;
      da = rand_data(); db = rand_data();
      wr_valid = 1'b1; wr_addr = 5'd8; wr_extra = 4'd2; wr_data = da;
      tick();
      wr_addr = 5'd20; wr_extra = 4'd1; wr_data = db;
      bad = 0;
      for (int c = 0; c <= 2; c++) begin
         if (wr_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad++;
         tick();
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL b2b_backpressure: bad_cycles=%0d required 0", bad);
      end
      tests++;
      if (done !== 1'b1 || wr_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_done_ready: done=%b wr_ready=%b required 1 1", done, wr_ready);
      end
      tick();
      wr_valid = 1'b0; wr_data = rand_data();
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         fails++;
         $display("FAIL b2b_second_start: busy=%b done=%b required 1 0", busy, done);
      end
      cnt = 0;
      while (done !== 1'b1 && cnt < 20) begin tick(); cnt++; end
      tests++;
      if (cnt !== 2) begin
         fails++;
         $display("FAIL b2b_second_latency: cycles=%0d required 2", cnt);
      end
      model_store(8, 2, da);
      model_store(20, 1, db);
      for (int a = 0; a < NPOS; a++) begin
         read_word(a, got);
         tests++;
         if (got !== ref_mem[a]) begin
            fails++;
            $display("FAIL b2b_mem[%0d]: got %h required %h", a, got, ref_mem[a]);
         end
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] old_v, new_v;
      old_v = ref_mem[4];
      new_v = ~old_v;
      rd_addr = 5'd4;
      wr_valid = 1'b1; wr_addr = 5'd4; wr_extra = 4'd0; wr_data = {120'h0, new_v};
      tick();
      wr_valid = 1'b0;
      tick();
      tests++;
      if (rd_data !== old_v || done !== 1'b1) begin
         fails++;
         $display("FAIL collision_old: rd_data=%h done=%b required %h 1", rd_data, done, old_v);
      end
      tick();
      tests++;
      if (rd_data !== new_v) begin
         fails++;
         $display("FAIL collision_new: rd_data=%h required %h", rd_data, new_v);
      end
      ref_mem[4] = new_v;
   endtask

   task automatic test_reset_mid();
      logic [DATA_W-1:0] d;
      logic [DW-1:0] got;
      int bad;
      d = rand_data();
      wr_valid = 1'b1; wr_addr = 5'd0; wr_extra = 4'd15; wr_data = d;
      tick();
      wr_valid = 1'b0; wr_data = rand_data();
      for (int c = 0; c < 5; c++) tick();
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_abort: busy=%b done=%b error=%b required 0 0 0", busy, done, error);
      end
      bad = 0;
      tick();
      if (done !== 1'b0 || error !== 1'b0 || rd_data !== 8'h00) bad++;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL reset_mid_quiet: bad_cycles=%0d required 0", bad);
      end
      for (int i = 0; i < 5; i++) ref_mem[i] = word_of(d, 15, i);
      for (int a = 0; a < NPOS; a++) begin
         read_word(a, got);
         tests++;
         if (got !== ref_mem[a]) begin
            fails++;
            $display("FAIL reset_mid_mem[%0d]: got %h required %h", a, got, ref_mem[a]);
         end
      end
   endtask

   task automatic test_random();
      int fd, nd, fe, ne, nb, nboth, addr, ext;
      logic [DATA_W-1:0] d;
      logic [DW-1:0] got;
      for (int t = 0; t < 24; t++) begin
         addr = $urandom_range(0, NPOS - 1);
         ext  = $urandom_range(0, 15);
         d    = rand_data();
         do_store(addr, ext, d, fd, nd, fe, ne, nb, nboth);
         tests++;
         if (store_fits(addr, ext)) begin
            if (fd !== ext + 1 || nd !== 1 || ne !== 0 || nb !== ext + 1 || nboth !== 0) begin
               fails++;
               $display("FAIL random_store a=%0d n=%0d: done_at=%0d n_done=%0d n_err=%0d busy=%0d required %0d 1 0 %0d",
                        addr, ext, fd, nd, ne, nb, ext + 1, ext + 1);
            end
         end else begin
            if (fe !== 0 || ne !== 1 || nd !== 0 || nb !== 0) begin
               fails++;
               $display("FAIL random_reject a=%0d n=%0d: err_at=%0d n_err=%0d n_done=%0d busy=%0d required 0 1 0 0",
                        addr, ext, fe, ne, nd, nb);
            end
         end
         model_store(addr, ext, d);
      end
      for (int a = 0; a < NPOS; a++) begin
         read_word(a, got);
         tests++;
         if (got !== ref_mem[a]) begin
            fails++;
            $display("FAIL random_mem[%0d]: got %h required %h", a, got, ref_mem[a]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_single();
      test_multi();
      test_boundary();
      test_back_to_back();
      test_collision();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/genram.md
GENRAM -- requirements
Module: genram

Interface
REQ-001 Parameter AW, default 5, address width in bits; memory holds NPOS = 2**AW words.
REQ-002 Parameter DW, default 8, word (byte) width in bits.
REQ-003 Parameter EXTRA, default 4, width of the length field; the data bus carries up to EXTRA**2 words.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_valid  input  1  store request present.
REQ-007 wr_ready  output  1  block can accept a store request this cycle.
REQ-008 wr_addr  input  AW  first word address of the store.
REQ-009 wr_extra  input  EXTRA  store length minus one, so wr_extra=n writes n+1 words.
REQ-010 wr_data  input  EXTRA**2*DW  packed store data; word i (0..n) is at bits [(n-i)*DW +: DW], so word 0 is the most significant of the low (n+1)*DW bits; bits above (n+1)*DW are ignored.
REQ-011 busy  output  1  a store is in progress.
REQ-012 done  output  1  one-cycle pulse when a store completes successfully.
REQ-013 error  output  1  one-cycle pulse when a store request is rejected.
REQ-014 rd_addr  input  AW  read port address.
REQ-015 rd_data  output  DW  registered read data.

Function
REQ-016 States: IDLE, WRITE, each encoded in the shared package enum.
REQ-017 wr_ready is 1 only in IDLE; a request is accepted on a rising edge with wr_valid=1 and wr_ready=1.
REQ-018 On accept, the block latches wr_addr, wr_extra and wr_data; later changes on those inputs have no effect on that store.
REQ-019 Range check: addr+extra >= NPOS is evaluated in AW+1 bits. If it holds, nothing is written, error pulses in the cycle after accept, and the state stays IDLE.
REQ-020 On a valid request the state goes to WRITE with index 0. Each WRITE cycle writes word idx to mem[addr+idx], then increments idx.
REQ-021 When idx equals the latched extra, that word is written, done pulses in the next cycle, and the state returns to IDLE.
REQ-022 Latency: accept to done is n+1 cycles for n+1 words; wr_ready is back to 1 in the same cycle done is 1.
REQ-023 busy equals (state == WRITE).
REQ-024 error and done are never 1 in the same cycle.
REQ-025 Read port: rd_data <= mem[rd_addr] every cycle, latency 1.
REQ-026 A read and a write to the same address in the same cycle return the old word (read-before-write).
REQ-027 Addresses never wrap; the range check guarantees addr+idx <= NPOS-1.

Reset
REQ-028 While rst_n=0: state is IDLE, idx=0, busy=0, done=0, error=0, rd_data=0, and wr_ready is 1 after release.
REQ-029 Reset asserted mid-store aborts the store immediately, with no done or error pulse; words already written keep their values, the rest are unchanged.
REQ-030 Memory contents are not reset.

Structure
REQ-031 Package wasm_mem_pkg holds the state enum typedef and a localparam helper for the data width EXTRA**2*DW.
REQ-032 Storage is a sub-module genram_core: one write port and one registered read port, no reset.
REQ-033 The control FSM, index counter and byte selection live in genram.

Verification (AW=5, DW=8, EXTRA=4)
REQ-034 Single word: addr=3, extra=0, data[7:0]=8'hA5 -> done 1 cycle after accept; reading addr 3 gives 8'hA5.
REQ-035 Multi-word: addr=4, extra=3, data[31:0]=32'h11223344 -> done 4 cycles after accept; addrs 4..7 read 11,22,33,44.
REQ-036 Boundary: addr=28, extra=3 -> accepted, words written to 28..31. addr=29, extra=3 -> error pulse, memory unchanged, no done.
REQ-037 Back-pressure: wr_valid held with a second request during WRITE -> wr_ready=0 until done; second store starts the cycle done=1.
REQ-038 Reset mid-store: addr=0, extra=15, rst_n low after 5 WRITE cycles -> addrs 0..4 written, 5..15 unchanged, busy=0, no done.
REQ-039 Read collision: read addr 4 in the cycle addr 4 is written -> rd_data shows the old value, then the new value on the next read.
